xdma_cfg_frame_collector: RTL and testbench

XDMA_CFG_FRAME_COLLECTOR -- requirements
Module: xdma_cfg_frame_collector

---
 rtl/xdma_pkg.sv | 44 ++++
 rtl/xdma_cfg_frame_collector.sv | 138 +++++++++++++
 tb/tb_xdma_cfg_frame_collector.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xdma_pkg.sv
// Shared widths, frame layouts and header type for the XDMA configuration path.
package xdma_pkg;

    localparam int unsigned AxiDataWidth            = 512;
    localparam int unsigned AddrWidth               = 48;
    localparam int unsigned DMAIdWidth              = 4;
    localparam int unsigned TotalFrameWidth         = 4;
    localparam int unsigned FirstFramePayloadOffset = 105;
    localparam int unsigned FirstPayloadWidth       = AxiDataWidth - FirstFramePayloadOffset;
    localparam int unsigned PayloadWidth            = AxiDataWidth - DMAIdWidth - 1;

    typedef logic [DMAIdWidth-1:0]      dma_id_t;
    typedef logic [AddrWidth-1:0]       addr_t;
    typedef logic [TotalFrameWidth-1:0] frame_len_t;

    typedef struct packed {
        logic [FirstPayloadWidth-1:0] payload;
        addr_t                        writer_addr;
        addr_t                        reader_addr;
        dma_id_t                      dma_id;
        frame_len_t                   frame_length;
        logic                         dma_type;
    } xdma_inter_cluster_first_cfg_t;

    typedef struct packed {
        logic [PayloadWidth-1:0] payload;
        logic                    dma_type;
        dma_id_t                 dma_id;
    } xdma_inter_cluster_cfg_t;

    typedef struct packed {
        dma_id_t    dma_id;
        logic       dma_type;
        frame_len_t frame_length;
        addr_t      reader_addr;
        addr_t      writer_addr;
    } xdma_cfg_header_t;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } xdma_cfg_state_e;

endpackage

// File: rtl/xdma_cfg_frame_collector.sv
// Collects remote cfg frames into a header plus per-frame payload stream.
// Define XDMA_CFG_ID_CHECK_EN to drop continuation frames whose id/type mismatch the header.
module xdma_cfg_frame_collector
    import xdma_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [AxiDataWidth-1:0]     frame_i,
    input  logic                        frame_valid_i,
    output logic                        frame_ready_o,
    output xdma_cfg_header_t            hdr_o,
    output logic                        hdr_valid_o,
    input  logic                        hdr_ready_i,
    output logic [PayloadWidth-1:0]     pld_o,
    output logic [TotalFrameWidth-1:0]  pld_idx_o,
    output logic                        pld_last_o,
    output logic                        pld_valid_o,
    input  logic                        pld_ready_i,
    output logic                        err_o
);

    xdma_cfg_state_e               state, state_next;
    frame_len_t                    remaining, index;
    xdma_inter_cluster_first_cfg_t first;
    xdma_inter_cluster_cfg_t       cont;
    logic                          hdr_free, pld_free, id_match;
    logic                          load_first, load_body;

    assign first    = frame_i;
    assign cont     = frame_i;
    assign hdr_free = !hdr_valid_o || hdr_ready_i;
    assign pld_free = !pld_valid_o || pld_ready_i;

`ifdef XDMA_CFG_ID_CHECK_EN
    logic drop;

    assign id_match = (cont.dma_id == hdr_o.dma_id) && (cont.dma_type == hdr_o.dma_type);
    assign drop     = (state == BODY) && frame_valid_i && pld_free && !id_match;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else begin
            err_o <= drop;
        end
    end
`else
    logic unused_cont_id;

    assign id_match       = 1'b1;
    assign unused_cont_id = ^{cont.dma_id, cont.dma_type};
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new header waits for both output slots; body frames only need the payload slot.
    always_comb begin
        state_next    = state;
        frame_ready_o = 1'b0;
        load_first    = 1'b0;
        load_body     = 1'b0;
        case (state)
            IDLE: begin
                frame_ready_o = hdr_free && pld_free;
                load_first    = frame_valid_i && frame_ready_o;
                if (load_first && (first.frame_length > frame_len_t'(1))) begin
                    state_next = BODY;
                end
            end
            BODY: begin
                frame_ready_o = pld_free;
                if (frame_valid_i && pld_free && id_match) begin
                    load_body = 1'b1;
                    if (remaining == frame_len_t'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hdr_o       <= '0;
            hdr_valid_o <= 1'b0;
            pld_o       <= '0;
            pld_idx_o   <= '0;
            pld_last_o  <= 1'b0;
            pld_valid_o <= 1'b0;
            remaining   <= '0;
            index       <= '0;
        end else begin
            if (load_first) begin
                hdr_valid_o        <= 1'b1;
                hdr_o.dma_id       <= first.dma_id;
                hdr_o.dma_type     <= first.dma_type;
                hdr_o.frame_length <= first.frame_length;
                hdr_o.reader_addr  <= first.reader_addr;
                hdr_o.writer_addr  <= first.writer_addr;
            end else if (hdr_ready_i) begin
                hdr_valid_o <= 1'b0;
            end

            // Length 0 and 1 both mean a single-frame transfer.
            if (load_first) begin
                pld_valid_o <= 1'b1;
                pld_o       <= PayloadWidth'(first.payload);
                pld_idx_o   <= '0;
                pld_last_o  <= (first.frame_length <= frame_len_t'(1));
                if (first.frame_length > frame_len_t'(1)) begin
                    remaining <= first.frame_length - 1'b1;
                    index     <= frame_len_t'(1);
                end else begin
                    remaining <= '0;
                    index     <= '0;
                end
            end else if (load_body) begin
                pld_valid_o <= 1'b1;
                pld_o       <= cont.payload;
                pld_idx_o   <= index;
                pld_last_o  <= (remaining == frame_len_t'(1));
                remaining   <= remaining - 1'b1;
                index       <= index + 1'b1;
            end else if (pld_ready_i) begin
                pld_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xdma_cfg_frame_collector.sv
// Scoreboard bench for xdma_cfg_frame_collector; adapts to XDMA_CFG_ID_CHECK_EN.
module tb_xdma_cfg_frame_collector;
    import xdma_pkg::*;

    typedef struct {
        logic [506:0] data;
        logic [3:0]   idx;
        logic         last;
    } pld_exp_t;

`ifdef XDMA_CFG_ID_CHECK_EN
    localparam bit IdCheck = 1'b1;
`else
    localparam bit IdCheck = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [511:0]     frame_i;
    logic             frame_valid_i;
    logic             frame_ready_o;
    xdma_cfg_header_t hdr_o;
    logic             hdr_valid_o;
    logic             hdr_ready_i;
    logic [506:0]     pld_o;
    logic [3:0]       pld_idx_o;
    logic             pld_last_o;
    logic             pld_valid_o;
    logic             pld_ready_i;
    logic             err_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int accept_cyc  = 0;
    int err_seen    = 0;
    bit rand_ready  = 1'b0;

    xdma_cfg_header_t hdr_q[$];
    pld_exp_t         pld_q[$];
    int               err_q[$];

    // Reference model state: which transfer is open and how far along it is.
    bit         m_body = 1'b0;
    logic [3:0] m_id;
    logic       m_type;
    int         m_left;
    int         m_idx;

    xdma_cfg_frame_collector dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .frame_i       (frame_i),
        .frame_valid_i (frame_valid_i),
        .frame_ready_o (frame_ready_o),
        .hdr_o         (hdr_o),
        .hdr_valid_o   (hdr_valid_o),
        .hdr_ready_i   (hdr_ready_i),
        .pld_o         (pld_o),
        .pld_idx_o     (pld_idx_o),
        .pld_last_o    (pld_last_o),
        .pld_valid_o   (pld_valid_o),
        .pld_ready_i   (pld_ready_i),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            hdr_ready_i = ($urandom_range(0, 3) != 0);
            pld_ready_i = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic check(input string name, input logic [511:0] actual, input logic [511:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] first_frame(input logic [3:0] id, input logic t, input logic [3:0] len,
                                                 input logic [47:0] ra, input logic [47:0] wa);
        logic [511:0] f;
        f         = rand512();
        f[0]      = t;
        f[4:1]    = len;
        f[8:5]    = id;
        f[56:9]   = ra;
        f[104:57] = wa;
        return f;
    endfunction

    function automatic logic [511:0] cont_frame(input logic [3:0] id, input logic t);
        logic [511:0] f;
        f      = rand512();
        f[3:0] = id;
        f[4]   = t;
        return f;
    endfunction

    // Expected outputs follow from the frame layouts and transfer rules alone.
    task automatic model_accept(input logic [511:0] f);
        if (!m_body) begin
            xdma_cfg_header_t h;
            int total;
            h.dma_id       = f[8:5];
            h.dma_type     = f[0];
            h.frame_length = f[4:1];
            h.reader_addr  = f[56:9];
            h.writer_addr  = f[104:57];
            hdr_q.push_back(h);
            total = (f[4:1] == 4'd0) ? 1 : int'(f[4:1]);
            pld_q.push_back('{data: {100'b0, f[511:105]}, idx: 4'd0, last: (total == 1)});
            if (total > 1) begin
                m_body = 1'b1;
                m_id   = f[8:5];
                m_type = f[0];
                m_left = total - 1;
                m_idx  = 1;
            end
        end else begin
            bit match;
            match = !IdCheck || ((f[3:0] == m_id) && (f[4] == m_type));
            if (match) begin
                pld_q.push_back('{data: f[511:5], idx: 4'(m_idx), last: (m_left == 1)});
                m_idx++;
                m_left--;
                if (m_left == 0) m_body = 1'b0;
            end else begin
                err_q.push_back(cyc + 1);
            end
        end
    endtask

    task automatic send_frame(input logic [511:0] f);
        bit done;
        done          = 1'b0;
        frame_i       = f;
        frame_valid_i = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (frame_ready_o) begin
                model_accept(f);
                accept_cyc = cyc;
                done       = 1'b1;
            end
        end
        if (!done) check("accept_timeout", 512'd0, 512'd1);
        @(posedge clk);
        #1;
        frame_valid_i = 1'b0;
    endtask

    // Monitor: compares every output handshake and err pulse against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hdr_valid_o && hdr_ready_i) begin
                if (hdr_q.size() == 0) begin
                    check("hdr_q_size", 512'(hdr_q.size()), 512'd1);
                end else begin
                    xdma_cfg_header_t e;
                    e = hdr_q.pop_front();
                    check("hdr", 512'(hdr_o), 512'(e));
                end
            end
            if (pld_valid_o && pld_ready_i) begin
                if (pld_q.size() == 0) begin
                    check("pld_q_size", 512'(pld_q.size()), 512'd1);
                end else begin
                    pld_exp_t p;
                    p = pld_q.pop_front();
                    check("pld_data", 512'(pld_o), 512'(p.data));
                    check("pld_idx", 512'(pld_idx_o), 512'(p.idx));
                    check("pld_last", 512'(pld_last_o), 512'(p.last));
                end
            end
            begin
                bit exp_err;
                exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
                if (exp_err) void'(err_q.pop_front());
                if (err_o) err_seen++;
                if (exp_err || err_o) check("err", 512'(err_o), 512'(exp_err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [511:0] f;
        logic [506:0] held;
        int c0, e0, rel;

        frame_i       = '0;
        frame_valid_i = 1'b0;
        hdr_ready_i   = 1'b1;
        pld_ready_i   = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hdr_valid", 512'(hdr_valid_o), 512'd0);
        check("rst_pld_valid", 512'(pld_valid_o), 512'd0);
        check("rst_err", 512'(err_o), 512'd0);
        check("rst_hdr", 512'(hdr_o), 512'd0);
        check("rst_pld", 512'(pld_o), 512'd0);
        check("rst_idx_last", 512'({pld_idx_o, pld_last_o}), 512'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-frame transfer, outputs one cycle after acceptance.
        send_frame(first_frame(4'd3, 1'b0, 4'd1, 48'h1000, 48'h2000));
        check("single_hdr_valid", 512'(hdr_valid_o), 512'd1);
        check("single_pld_valid", 512'(pld_valid_o), 512'd1);
        check("single_id", 512'(hdr_o.dma_id), 512'd3);
        check("single_raddr", 512'(hdr_o.reader_addr), 512'h1000);
        check("single_waddr", 512'(hdr_o.writer_addr), 512'h2000);
        check("single_last", 512'(pld_last_o), 512'd1);
        check("single_idle_ready", 512'(frame_ready_o), 512'd1);

        // Three frames at full throughput.
        send_frame(first_frame(4'd5, 1'b1, 4'd3, 48'h0, 48'h40));
        c0 = accept_cyc;
        send_frame(cont_frame(4'd5, 1'b1));
        check("b2b_gap1", 512'(accept_cyc - c0), 512'd1);
        c0 = accept_cyc;
        send_frame(cont_frame(4'd5, 1'b1));
        check("b2b_gap2", 512'(accept_cyc - c0), 512'd1);

        // Mismatching continuation frame.
        e0 = err_seen;
        send_frame(first_frame(4'd5, 1'b0, 4'd2, 48'h11, 48'h22));
        send_frame(cont_frame(4'd6, 1'b0));
        if (IdCheck) send_frame(cont_frame(4'd5, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        check("err_pulses", 512'(err_seen - e0), 512'(IdCheck ? 1 : 0));

        // Payload back-pressure, then same-cycle reload on release.
        send_frame(first_frame(4'd9, 1'b1, 4'd3, 48'h33, 48'h44));
        pld_ready_i   = 1'b0;
        f             = cont_frame(4'd9, 1'b1);
        frame_i       = f;
        frame_valid_i = 1'b1;
        held          = pld_o;
        repeat (4) begin
            @(negedge clk);
            check("stall_pld", 512'(pld_o), 512'(held));
            check("stall_ready", 512'(frame_ready_o), 512'd0);
        end
        @(posedge clk);
        #1;
        pld_ready_i = 1'b1;
        #1;
        check("release_ready", 512'(frame_ready_o && pld_valid_o), 512'd1);
        rel = cyc;
        send_frame(f);
        check("release_same_cycle", 512'(accept_cyc - rel), 512'd0);
        send_frame(cont_frame(4'd9, 1'b1));

        // Header back-pressure blocks the next transfer; length 0 acts as 1.
        hdr_ready_i = 1'b0;
        send_frame(first_frame(4'd2, 1'b0, 4'd1, 48'h55, 48'h66));
        f             = first_frame(4'd4, 1'b1, 4'd0, 48'h77, 48'h88);
        frame_i       = f;
        frame_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hdr_block_ready", 512'(frame_ready_o), 512'd0);
        end
        @(posedge clk);
        #1;
        hdr_ready_i = 1'b1;
        send_frame(f);
        check("len0_last", 512'(pld_last_o), 512'd1);

        // Asynchronous reset in the middle of a transfer.
        send_frame(first_frame(4'd7, 1'b0, 4'd4, 48'h99, 48'haa));
        send_frame(cont_frame(4'd7, 1'b0));
        pld_ready_i = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hdr_valid", 512'(hdr_valid_o), 512'd0);
        check("arst_pld_valid", 512'(pld_valid_o), 512'd0);
        check("arst_outputs", 512'({hdr_o, pld_idx_o, pld_last_o, err_o}), 512'd0);
        check("arst_pld", 512'(pld_o), 512'd0);
        m_body = 1'b0;
        hdr_q.delete();
        pld_q.delete();
        err_q.delete();
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        pld_ready_i = 1'b1;
        send_frame(first_frame(4'd1, 1'b1, 4'd1, 48'hbeef, 48'hcafe));
        check("post_rst_raddr", 512'(hdr_o.reader_addr), 512'hbeef);
        check("post_rst_waddr", 512'(hdr_o.writer_addr), 512'hcafe);

        // Randomized transfers with random back-pressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [3:0] id, len;
            logic       ty;
            int         total;
            id    = 4'($urandom);
            ty    = 1'($urandom);
            len   = 4'($urandom_range(0, 5));
            total = (len == 4'd0) ? 1 : int'(len);
            send_frame(first_frame(id, ty, len, 48'({$urandom, $urandom}), 48'({$urandom, $urandom})));
            for (int k = 1; k < total; k++) begin
                if (IdCheck && $urandom_range(0, 4) == 0) begin
                    send_frame(cont_frame(id ^ 4'($urandom_range(1, 15)), ty));
                end
                send_frame(cont_frame(id, ty));
            end
        end
        rand_ready = 1'b0;
        #2;
        hdr_ready_i = 1'b1;
        pld_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("drain_hdr", 512'(hdr_q.size()), 512'd0);
        check("drain_pld", 512'(pld_q.size()), 512'd0);
        check("drain_err", 512'(err_q.size()), 512'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
